// File: rtl/capture_sequencer.sv
// ADC-to-buffer stream router with a SYSREF-aligned, delayed,
// fixed-length capture burst sequencer for the PL capture buffers.
module capture_sequencer #(
  parameter int NADC       = 8,
  parameter int NBUF       = 4,
  parameter int DATA_WIDTH = 128,
  parameter int SEL_BITS   = 3,
  parameter int LEN_BITS   = 16,
  parameter int DLY_BITS   = 16
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  input  logic                         capture_i,
  input  logic                         sysref_i,
  input  logic                         align_en_i,
  input  logic [NBUF-1:0]              buf_en_i,
  input  logic [NBUF*SEL_BITS-1:0]     chan_sel_i,
  input  logic [DLY_BITS-1:0]          delay_i,
  input  logic [LEN_BITS-1:0]          length_i,
  input  logic [NADC*DATA_WIDTH-1:0]   adc_tdata_i,
  output logic [NBUF*DATA_WIDTH-1:0]   buf_tdata_o,
  output logic [NBUF-1:0]              buf_tvalid_o,
  input  logic [NBUF-1:0]              buf_tready_i,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         overflow_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ALIGN,
    S_DELAY,
    S_CAPTURE,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_nx;

  (* ASYNC_REG = "TRUE" *) logic r_cap_s1;
  (* ASYNC_REG = "TRUE" *) logic r_cap_s2;
  logic r_cap_s3;
  logic r_sr_q;
  logic r_sr_qq;
  logic w_start;
  logic w_rise;
  logic w_idle;

  logic [NBUF-1:0]          r_en;
  logic [NBUF-1:0]          w_en;
  logic [NBUF-1:0]          r_tvalid;
  logic [NBUF*SEL_BITS-1:0] r_sel;
  logic [NBUF*SEL_BITS-1:0] w_sel;
  logic [DLY_BITS-1:0]      r_dly;
  logic [DLY_BITS-1:0]      w_dly;
  logic [DLY_BITS-1:0]      r_cnt;
  logic [LEN_BITS-1:0]      r_len;
  logic [LEN_BITS-1:0]      w_len;
  logic [LEN_BITS-1:0]      r_beat;
  logic                     r_busy;
  logic                     r_done;
  logic                     r_ovf;

  logic [DATA_WIDTH-1:0] w_adc   [NADC];
  logic [SEL_BITS-1:0]   w_ch    [NBUF];
  logic [DATA_WIDTH-1:0] r_tdata [NBUF];

  function automatic state_t f_arm(
    input logic [DLY_BITS-1:0] d,
    input logic [LEN_BITS-1:0] l
  );
    if (d != '0)      return S_DELAY;
    else if (l != '0) return S_CAPTURE;
    else              return S_DONE;
  endfunction

  assign w_start = r_cap_s2 & ~r_cap_s3;
  assign w_rise  = r_sr_q & ~r_sr_qq;
  assign w_idle  = (r_state == S_IDLE);

  // In IDLE the live inputs are what gets latched on a start event
  assign w_en  = w_idle ? buf_en_i   : r_en;
  assign w_sel = w_idle ? chan_sel_i : r_sel;
  assign w_dly = w_idle ? delay_i    : r_dly;
  assign w_len = w_idle ? length_i   : r_len;

  for (genvar n = 0; n < NADC; n++) begin : g_adc
    assign w_adc[n] = adc_tdata_i[n*DATA_WIDTH +: DATA_WIDTH];
  end

  for (genvar b = 0; b < NBUF; b++) begin : g_buf
    assign buf_tdata_o[b*DATA_WIDTH +: DATA_WIDTH] = r_tdata[b];
  end

  always_comb begin
    for (int b = 0; b < NBUF; b++) begin
      w_ch[b] = w_sel[b*SEL_BITS +: SEL_BITS];
      if (int'(w_ch[b]) >= NADC) w_ch[b] = '0;
    end
  end

  always_comb begin
    w_nx = r_state;
    unique case (r_state)
      S_IDLE:
        if (w_start)
          w_nx = align_en_i ? S_ALIGN : f_arm(w_dly, w_len);
      S_ALIGN:
        if (w_rise) w_nx = f_arm(w_dly, w_len);
      S_DELAY:
        if (r_cnt == DLY_BITS'(1))
          w_nx = (r_len != '0) ? S_CAPTURE : S_DONE;
      S_CAPTURE:
        if (r_beat == r_len - LEN_BITS'(1)) w_nx = S_DONE;
      S_DONE:
        w_nx = S_IDLE;
      default:
        w_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_state  <= S_IDLE;
      r_cap_s1 <= 1'b0;
      r_cap_s2 <= 1'b0;
      r_cap_s3 <= 1'b0;
      r_sr_q   <= 1'b0;
      r_sr_qq  <= 1'b0;
      r_en     <= '0;
      r_sel    <= '0;
      r_dly    <= '0;
      r_len    <= '0;
      r_cnt    <= '0;
      r_beat   <= '0;
      r_tvalid <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_ovf    <= 1'b0;
      for (int b = 0; b < NBUF; b++) r_tdata[b] <= '0;
    end else begin
      r_cap_s1 <= capture_i;
      r_cap_s2 <= r_cap_s1;
      r_cap_s3 <= r_cap_s2;
      r_sr_q   <= sysref_i;
      r_sr_qq  <= r_sr_q;

      r_state  <= w_nx;
      r_busy   <= (w_nx != S_IDLE);
      r_done   <= (w_nx == S_DONE);
      r_tvalid <= (w_nx == S_CAPTURE) ? w_en : '0;

      if (w_idle && w_start) begin
        r_en  <= buf_en_i;
        r_sel <= chan_sel_i;
        r_dly <= delay_i;
        r_len <= length_i;
      end

      // Data cannot stall: a refused beat is simply lost and flagged
      if (w_idle && w_start)
        r_ovf <= 1'b0;
      else if (|(r_tvalid & ~buf_tready_i))
        r_ovf <= 1'b1;

      if (w_nx == S_DELAY && r_state != S_DELAY)
        r_cnt <= w_dly;
      else if (r_state == S_DELAY)
        r_cnt <= r_cnt - DLY_BITS'(1);

      r_beat <= (r_state == S_CAPTURE) ? r_beat + LEN_BITS'(1) : '0;

      for (int b = 0; b < NBUF; b++) r_tdata[b] <= w_adc[w_ch[b]];
    end
  end

  assign buf_tvalid_o = r_tvalid;
  assign busy_o       = r_busy;
  assign done_o       = r_done;
  assign overflow_o   = r_ovf;

endmodule

// File: tb/tb_capture_sequencer.sv
// Randomized bench for capture_sequencer: a timeline model predicts
// busy/done/overflow/tvalid/tdata every cycle, plus pinned literals.
module tb_capture_sequencer;
  localparam int NADC = 8;
  localparam int NBUF = 4;
  localparam int DW   = 128;
  localparam int SB   = 3;
  localparam int LB   = 16;
  localparam int DB   = 16;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  logic capture_i = 1'b0;
  logic sysref_i = 1'b0;
  logic align_en_i = 1'b0;
  logic [NBUF-1:0] buf_en_i = '0;
  logic [NBUF-1:0] buf_tready_i = '1;
  logic [NBUF*SB-1:0] chan_sel_i = '0;
  logic [DB-1:0] delay_i = '0;
  logic [LB-1:0] length_i = '0;
  logic [NADC*DW-1:0] adc_tdata_i = '0;
  wire [NBUF*DW-1:0] buf_tdata_o;
  wire [NBUF-1:0] buf_tvalid_o;
  wire busy_o;
  wire done_o;
  wire overflow_o;

  capture_sequencer #(
    .NADC(NADC), .NBUF(NBUF), .DATA_WIDTH(DW),
    .SEL_BITS(SB), .LEN_BITS(LB), .DLY_BITS(DB)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .capture_i(capture_i), .sysref_i(sysref_i),
    .align_en_i(align_en_i), .buf_en_i(buf_en_i),
    .chan_sel_i(chan_sel_i), .delay_i(delay_i),
    .length_i(length_i), .adc_tdata_i(adc_tdata_i),
    .buf_tdata_o(buf_tdata_o), .buf_tvalid_o(buf_tvalid_o),
    .buf_tready_i(buf_tready_i), .busy_o(busy_o),
    .done_o(done_o), .overflow_o(overflow_o)
  );

  always #5 aclk = ~aclk;

  int cyc = 0;
  always @(posedge aclk) cyc++;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d act=%0h exp=%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic chki(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d act=%0d exp=%0d", nm, cyc, act, exp);
    end
  endtask

  // ADC sources: random, optionally channel 5 carries the cycle count
  bit adc_ramp = 1'b0;
  always @(posedge aclk) begin
    #1;
    for (int n = 0; n < NADC; n++)
      for (int w = 0; w < DW / 32; w++)
        adc_tdata_i[n*DW + w*32 +: 32] = $urandom;
    if (adc_ramp) adc_tdata_i[5*DW +: DW] = DW'(cyc);
  end

  int sr_half = 0;
  int sr_cnt = 0;
  always @(posedge aclk) begin
    #1;
    if (sr_half == 0) begin
      sysref_i = 1'b0;
      sr_cnt = 0;
    end else begin
      sr_cnt++;
      if (sr_cnt >= sr_half) begin
        sr_cnt = 0;
        sysref_i = ~sysref_i;
      end
    end
  end

  // Timeline model: a burst is [s_c, s_c+len) with done at s_c+len
  bit mv = 1'b0;
  bit a0, a1, a2, b0, b1;
  bit act_m, pend;
  int s_c, d_c, m_dly, m_len;
  logic [NBUF-1:0] m_en;
  logic [SB-1:0] m_sel [NBUF];
  bit e_busy, e_done, e_ovf, e_rst;
  logic [NBUF-1:0] e_val;
  logic [DW-1:0] e_dat [NBUF];

  int n_v [NBUF];
  int n_done, n_busy, first_v, sr_edge;
  bit sr_arm = 1'b0;
  bit sr_prev = 1'b0;
  logic [DW-1:0] f_dat;

  function automatic int chmap(input logic [SB-1:0] s);
    return (int'(s) >= NADC) ? 0 : int'(s);
  endfunction

  always @(negedge aclk) begin
    int k;
    bit st, rs, was;
    logic [NBUF-1:0] vk;
    k = cyc;
    if (mv) begin
      chk("busy", DW'(busy_o), DW'(e_busy));
      chk("done", DW'(done_o), DW'(e_done));
      chk("overflow", DW'(overflow_o), DW'(e_ovf));
      chk("tvalid", DW'(buf_tvalid_o), DW'(e_val));
      for (int b = 0; b < NBUF; b++) begin
        if (e_val[b])
          chk($sformatf("tdata%0d", b), buf_tdata_o[b*DW +: DW], e_dat[b]);
        else if (e_rst)
          chk($sformatf("tdata_rst%0d", b), buf_tdata_o[b*DW +: DW], '0);
      end
    end
    for (int b = 0; b < NBUF; b++) if (buf_tvalid_o[b]) n_v[b]++;
    if (done_o) n_done++;
    if (busy_o) n_busy++;
    if (buf_tvalid_o != '0 && first_v < 0) begin
      first_v = k;
      f_dat = buf_tdata_o[DW-1:0];
    end
    if (sr_arm && sysref_i && !sr_prev) begin
      sr_edge = k + 1;
      sr_arm = 1'b0;
    end
    sr_prev = sysref_i;

    if (!aresetn) begin
      mv = 1'b1;
      {a0, a1, a2, b0, b1} = '0;
      act_m = 1'b0;
      pend = 1'b0;
      {e_busy, e_done, e_ovf} = '0;
      e_val = '0;
      e_rst = 1'b1;
    end else if (mv) begin
      st = a1 & ~a2;
      rs = b0 & ~b1;
      was = act_m;
      vk = e_val;
      if (act_m && pend && rs) begin
        pend = 1'b0;
        s_c = k + 1 + m_dly;
        d_c = s_c + m_len;
      end
      if (was && !pend && k == d_c) act_m = 1'b0;
      if (!was && st) begin
        act_m = 1'b1;
        m_en = buf_en_i;
        for (int b = 0; b < NBUF; b++) m_sel[b] = chan_sel_i[b*SB +: SB];
        m_dly = int'(delay_i);
        m_len = int'(length_i);
        e_ovf = 1'b0;
        if (align_en_i) pend = 1'b1;
        else begin
          s_c = k + 1 + m_dly;
          d_c = s_c + m_len;
        end
      end
      if (|(vk & ~buf_tready_i)) e_ovf = 1'b1;
      a2 = a1; a1 = a0; a0 = capture_i;
      b1 = b0; b0 = sysref_i;
      e_busy = act_m;
      e_done = act_m && !pend && (k + 1 == d_c);
      e_val = (act_m && !pend && k + 1 >= s_c && k + 1 < s_c + m_len)
              ? m_en : '0;
      for (int b = 0; b < NBUF; b++)
        e_dat[b] = adc_tdata_i[chmap(m_sel[b])*DW +: DW];
      e_rst = 1'b0;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic clr_m();
    for (int b = 0; b < NBUF; b++) n_v[b] = 0;
    n_done = 0;
    n_busy = 0;
    first_v = -1;
    sr_edge = -1;
  endtask

  task automatic start_cap();
    capture_i = 1'b1;
    step(4);
    capture_i = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int t;
    t = 0;
    while ((busy_o || act_m) && t < budget) begin
      step(1);
      t++;
    end
    chki("idle_timeout", int'(t < budget), 1);
    step(2);
  endtask

  int j;

  initial begin
    clr_m();
    step(3);
    aresetn = 1'b1;
    chk("rst_busy", DW'(busy_o), '0);
    chk("rst_tvalid", DW'(buf_tvalid_o), '0);
    chk("rst_done", DW'(done_o), '0);
    chk("rst_ovf", DW'(overflow_o), '0);
    chk("rst_tdata0", buf_tdata_o[DW-1:0], '0);
    step(4);

    // Basic unaligned burst from adc5
    adc_ramp = 1'b1;
    align_en_i = 1'b0; delay_i = 0; length_i = 4;
    buf_en_i = 4'b0001; chan_sel_i = 12'(5);
    clr_m();
    j = cyc;
    start_cap();
    wait_idle(200);
    chki("t1_latency", first_v - j, 3);
    chk("t1_first_data", f_dat, DW'(first_v - 1));
    chki("t1_beats", n_v[0], 4);
    chki("t1_other_beats", n_v[1] + n_v[2] + n_v[3], 0);
    chki("t1_busy", n_busy, 5);
    chki("t1_done", n_done, 1);
    chk("t1_ovf", DW'(overflow_o), '0);
    adc_ramp = 1'b0;

    // SYSREF-aligned, delayed, all buffers
    align_en_i = 1'b1; delay_i = 10; length_i = 8;
    buf_en_i = 4'b1111;
    chan_sel_i = {3'd7, 3'd2, 3'd0, 3'd3};
    clr_m();
    start_cap();
    sr_arm = 1'b1;
    sr_half = 24;
    wait_idle(300);
    sr_half = 0;
    chki("t2_align_lat", first_v - sr_edge, 11);
    for (int b = 0; b < NBUF; b++) chki("t2_beats", n_v[b], 8);
    chki("t2_done", n_done, 1);

    // Zero-length burst with delay
    align_en_i = 1'b0; delay_i = 3; length_i = 0;
    clr_m();
    start_cap();
    wait_idle(100);
    chki("t3_busy", n_busy, 4);
    chki("t3_beats", n_v[0] + n_v[1] + n_v[2] + n_v[3], 0);
    chki("t3_done", n_done, 1);

    // Backpressure on buffer 1
    delay_i = 0; length_i = 16;
    clr_m();
    start_cap();
    step(3);
    buf_tready_i[1] = 1'b0;
    step(2);
    buf_tready_i[1] = 1'b1;
    wait_idle(100);
    chk("t4_ovf_sticky", DW'(overflow_o), 1);
    chki("t4_beats", n_v[1], 16);
    chki("t4_done", n_done, 1);

    // Second request and config change mid-burst are ignored
    delay_i = 2; length_i = 20;
    clr_m();
    start_cap();
    chk("t5_ovf_clr", DW'(overflow_o), '0);
    step(6);
    capture_i = 1'b1;
    length_i = 3;
    chan_sel_i = 12'h123;
    step(4);
    capture_i = 1'b0;
    wait_idle(200);
    chki("t5_beats", n_v[0], 20);
    chki("t5_done", n_done, 1);

    // Reset in the middle of a burst
    delay_i = 0; length_i = 30;
    clr_m();
    start_cap();
    step(8);
    aresetn = 1'b0;
    step(1);
    aresetn = 1'b1;
    chk("t6_busy", DW'(busy_o), '0);
    chk("t6_tvalid", DW'(buf_tvalid_o), '0);
    step(5);
    chki("t6_no_done", n_done, 0);
    length_i = 5;
    clr_m();
    start_cap();
    wait_idle(100);
    chki("t6_beats", n_v[0], 5);
    chki("t6_done", n_done, 1);

    // Randomized traffic against the model
    for (int it = 0; it < 40; it++) begin
      sr_half = $urandom_range(2, 20);
      for (int c = 0; c < 120; c++) begin
        align_en_i = 1'($urandom_range(0, 1));
        delay_i = DB'($urandom_range(0, 12));
        length_i = LB'($urandom_range(0, 40));
        buf_en_i = NBUF'($urandom);
        chan_sel_i = (NBUF*SB)'($urandom);
        buf_tready_i = ($urandom_range(0, 7) == 0) ? NBUF'($urandom) : '1;
        if ($urandom_range(0, 15) == 0) capture_i = ~capture_i;
        aresetn = ($urandom_range(0, 199) != 0);
        step(1);
      end
    end
    aresetn = 1'b1;
    capture_i = 1'b0;
    buf_tready_i = '1;
    wait_idle(600);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
